// File: rtl/axi_lite_apb_bridge_if.sv
// axi_lite_apb_bridge_if: AXI4-Lite slave channels plus APB3 requester signals for the bridge.
interface axi_lite_apb_bridge_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic                    AWVALID;
    logic [2:0]              AWPROT;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic                    BRESP;
    logic                    BVALID;
    logic                    BREADY;
    logic [ADDR_WIDTH-1:0]   ARADDR;
    logic                    ARVALID;
    logic                    ARREADY;
    logic [DATA_WIDTH-1:0]   RDATA;
    logic                    RRESP;
    logic                    RVALID;
    logic                    RREADY;
    logic [ADDR_WIDTH-1:0]   PADDR;
    logic [DATA_WIDTH-1:0]   PWDATA;
    logic                    PSEL;
    logic                    PENABLE;
    logic                    PWRITE;
    logic [DATA_WIDTH-1:0]   PRDATA;
    logic                    PREADY;
    logic                    PSLVERR;

    modport slave (
        input  AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARVALID, RREADY, PRDATA, PREADY, PSLVERR,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
               PADDR, PWDATA, PSEL, PENABLE, PWRITE
    );

    modport master (
        output AWADDR, AWVALID, AWPROT, WDATA, WSTRB, WVALID, BREADY,
               ARADDR, ARVALID, RREADY, PRDATA, PREADY, PSLVERR,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID,
               PADDR, PWDATA, PSEL, PENABLE, PWRITE
    );
endinterface

// File: rtl/axi_lite_apb_bridge.sv
// axi_lite_apb_bridge: AXI4-Lite slave to APB3 requester, one transaction in flight.
// Define AXI_APB_BRIDGE_TIMEOUT_EN to end an APB access with an error after 256 wait cycles.
module axi_lite_apb_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic                  ACLK,
    input logic                  ARESETn,
    axi_lite_apb_bridge_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e                state_q;
    logic                  rd_pri_q, psel_q, penable_q, pwrite_q;
    logic                  bvalid_q, bresp_q, rvalid_q, rresp_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q, rdata_q;
    logic                  wr_req, rd_req, idle, wr_gnt, rd_gnt;
`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
    logic [7:0]            cnt_q;
`endif

    // Readies are combinational so the grant lands in the same IDLE cycle the request appears.
    always_comb begin
        wr_req = bus.AWVALID && bus.WVALID;
        rd_req = bus.ARVALID;
        idle   = ARESETn && state_q == IDLE;
        rd_gnt = idle && rd_req && (rd_pri_q || !wr_req);
        wr_gnt = idle && wr_req && !rd_gnt;
    end

    assign bus.AWREADY = wr_gnt;
    assign bus.WREADY  = wr_gnt;
    assign bus.ARREADY = rd_gnt;
    assign bus.PSEL    = psel_q;
    assign bus.PENABLE = penable_q;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PADDR   = paddr_q;
    assign bus.PWDATA  = pwdata_q;
    assign bus.BVALID  = bvalid_q;
    assign bus.BRESP   = bresp_q;
    assign bus.RVALID  = rvalid_q;
    assign bus.RRESP   = rresp_q;
    assign bus.RDATA   = rdata_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q   <= IDLE;
            rd_pri_q  <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= 1'b0;
            rdata_q   <= '0;
`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_gnt || rd_gnt) begin
                        state_q  <= SETUP;
                        psel_q   <= 1'b1;
                        pwrite_q <= wr_gnt;
                        paddr_q  <= wr_gnt ? bus.AWADDR : bus.ARADDR;
                        pwdata_q <= wr_gnt ? bus.WDATA : '0;
                        rd_pri_q <= wr_gnt;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
                    cnt_q     <= '0;
`endif
                end
                ACCESS: begin
`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
                    cnt_q <= cnt_q + 8'd1;
                    if (!bus.PREADY && cnt_q == 8'hff) begin
                        state_q   <= RESP;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        bvalid_q  <= pwrite_q;
                        rvalid_q  <= !pwrite_q;
                        bresp_q   <= pwrite_q;
                        rresp_q   <= !pwrite_q;
                        rdata_q   <= '0;
                    end
`endif
                    if (bus.PREADY) begin
                        state_q   <= RESP;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        bvalid_q  <= pwrite_q;
                        rvalid_q  <= !pwrite_q;
                        bresp_q   <= pwrite_q && bus.PSLVERR;
                        rresp_q   <= !pwrite_q && bus.PSLVERR;
                        rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
                    end
                end
                RESP: begin
                    if ((bvalid_q && bus.BREADY) || (rvalid_q && bus.RREADY)) begin
                        state_q  <= IDLE;
                        bvalid_q <= 1'b0;
                        rvalid_q <= 1'b0;
                        bresp_q  <= 1'b0;
                        rresp_q  <= 1'b0;
                        rdata_q  <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_apb_bridge.sv
// tb_axi_lite_apb_bridge: directed and randomized checks of the AXI-Lite to APB3 bridge.
module tb_axi_lite_apb_bridge;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    int          n_run = 0;
    int          n_fail = 0;
    int          apb_wait = 0;
    bit          apb_stall = 1'b0;
    bit          apb_err = 1'b0;
    logic [31:0] apb_rdata = '0;

    axi_lite_apb_bridge_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    axi_lite_apb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (.ACLK(clk), .ARESETn(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // APB completer: inserts apb_wait wait states, returns junk data until it is ready.
    initial begin : apb_completer
        int wcnt;
        wcnt = 0;
        bus.PREADY = 1'b0;
        bus.PRDATA = '0;
        bus.PSLVERR = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.PSEL && bus.PENABLE) begin
                bus.PREADY = !apb_stall && wcnt >= apb_wait;
                bus.PRDATA = bus.PREADY ? apb_rdata : $urandom;
                bus.PSLVERR = bus.PREADY && apb_err;
                wcnt++;
            end else begin
                bus.PREADY = 1'b0;
                bus.PRDATA = '0;
                bus.PSLVERR = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic clear_inputs();
        bus.AWADDR = '0; bus.AWVALID = 1'b0; bus.AWPROT = 3'b000;
        bus.WDATA = '0; bus.WSTRB = 4'hf; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARVALID = 1'b0; bus.RREADY = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int limit, output bit ok);
        int cyc;
        cyc = 0;
        while (!(bus.BVALID || bus.RVALID) && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
        ok = bus.BVALID || bus.RVALID;
    endtask

    task automatic test_reset();
        clear_inputs();
        #2 rst_n = 1'b0;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
        bus.AWADDR = '1; bus.WDATA = '1; bus.ARADDR = '1;
        repeat (2) @(negedge clk);
        #1;
        n_run++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ready: got %b, expected 000", {bus.AWREADY, bus.WREADY, bus.ARREADY});
        end
        n_run++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== 67'h0) begin
            n_fail++; $display("FAIL reset_apb: got %h, expected 0", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA});
        end
        n_run++;
        if ({bus.BVALID, bus.BRESP, bus.RVALID, bus.RRESP, bus.RDATA} !== 36'h0) begin
            n_fail++; $display("FAIL reset_resp: got %h, expected 0", {bus.BVALID, bus.BRESP, bus.RVALID, bus.RRESP, bus.RDATA});
        end
        clear_inputs();
    endtask

    // Reset released together with the request: grant must be immediate.
    task automatic test_read_basic();
        @(negedge clk);
        rst_n = 1'b1;
        apb_wait = 0; apb_err = 1'b0; apb_rdata = 32'hDEADBEEF;
        bus.RREADY = 1'b1; bus.ARADDR = 32'h10; bus.ARVALID = 1'b1;
        #1;
        n_run++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b001) begin
            n_fail++; $display("FAIL read_grant: got %b, expected 001", {bus.AWREADY, bus.WREADY, bus.ARREADY});
        end
        @(negedge clk);
        bus.ARVALID = 1'b0;
        #1;
        n_run++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA} !== {3'b100, 32'h10, 32'h0}) begin
            n_fail++; $display("FAIL read_setup: got %h, expected %h", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA}, {3'b100, 32'h10, 32'h0});
        end
        @(negedge clk);
        n_run++;
        if ({bus.PSEL, bus.PENABLE, bus.RVALID} !== 3'b110) begin
            n_fail++; $display("FAIL read_access: got %b, expected 110", {bus.PSEL, bus.PENABLE, bus.RVALID});
        end
        @(negedge clk);
        n_run++;
        if ({bus.RVALID, bus.RRESP, bus.RDATA, bus.PSEL, bus.PENABLE} !== {2'b10, 32'hDEADBEEF, 2'b00}) begin
            n_fail++; $display("FAIL read_resp: got %h, expected %h", {bus.RVALID, bus.RRESP, bus.RDATA, bus.PSEL, bus.PENABLE}, {2'b10, 32'hDEADBEEF, 2'b00});
        end
        @(negedge clk);
        bus.RREADY = 1'b0;
        n_run++;
        if ({bus.RVALID, bus.RDATA} !== 33'h0) begin
            n_fail++; $display("FAIL read_done: got %h, expected 0", {bus.RVALID, bus.RDATA});
        end
    endtask

    task automatic test_write_wait();
        int cyc, bad, acc;
        @(negedge clk);
        apb_wait = 3; apb_err = 1'b1;
        bus.AWADDR = 32'h20; bus.WDATA = 32'h12345678; bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
        #1;
        n_run++;
        if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== 3'b110) begin
            n_fail++; $display("FAIL write_grant: got %b, expected 110", {bus.AWREADY, bus.WREADY, bus.ARREADY});
        end
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        cyc = 0; bad = 0; acc = 0;
        while (!bus.BVALID && cyc < 20) begin
            if (bus.PSEL) begin
                if (!bus.PWRITE || bus.PWDATA !== 32'h12345678 || bus.PADDR !== 32'h20) bad++;
                if (bus.PENABLE) acc++;
            end
            @(negedge clk);
            cyc++;
        end
        n_run++;
        if (bad != 0 || acc != 4) begin
            n_fail++; $display("FAIL write_apb: got %0d bad cycles and %0d access cycles, expected 0 and 4", bad, acc);
        end
        n_run++;
        if ({bus.BVALID, bus.BRESP, bus.RVALID} !== 3'b110) begin
            n_fail++; $display("FAIL write_resp: got %b, expected 110", {bus.BVALID, bus.BRESP, bus.RVALID});
        end
        @(negedge clk);
        bus.BREADY = 1'b0;
        n_run++;
        if (bus.BVALID !== 1'b0) begin
            n_fail++; $display("FAIL write_done: got %b, expected 0", bus.BVALID);
        end
    endtask

    task automatic test_partial();
        int bad;
        bit ok;
        @(negedge clk);
        apb_wait = 0; apb_err = 1'b0;
        bus.AWADDR = 32'h44; bus.WDATA = 32'h55; bus.AWVALID = 1'b1; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
        #1;
        bad = 0;
        repeat (5) begin
            if (bus.AWREADY || bus.WREADY || bus.ARREADY || bus.PSEL) bad++;
            @(negedge clk);
            #1;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++; $display("FAIL partial_nogrant: got %0d granting cycles, expected 0", bad);
        end
        bus.WVALID = 1'b1;
        #1;
        n_run++;
        if ({bus.AWREADY, bus.WREADY} !== 2'b11) begin
            n_fail++; $display("FAIL partial_grant: got %b, expected 11", {bus.AWREADY, bus.WREADY});
        end
        @(negedge clk);
        bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
        wait_valid(20, ok);
        n_run++;
        if ({ok, bus.BVALID, bus.BRESP} !== 3'b110) begin
            n_fail++; $display("FAIL partial_resp: got %b, expected 110", {ok, bus.BVALID, bus.BRESP});
        end
        @(negedge clk);
        bus.BREADY = 1'b0;
    endtask

    task automatic test_random();
        bit m_rd_pri;
        do_reset();
        m_rd_pri = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int mode, cyc, bad, dly;
            bit ew, err;
            logic [31:0] aw, ar, wd, prd, exp_addr, exp_wdata;
            logic [35:0] exp_rsp, obs_rsp;
            mode = $urandom_range(0, 2);
            aw = $urandom; ar = $urandom; wd = $urandom; prd = $urandom;
            err = 1'($urandom_range(0, 1));
            ew = (mode == 1) || (mode == 2 && !m_rd_pri);
            m_rd_pri = ew;
            exp_addr = ew ? aw : ar;
            exp_wdata = ew ? wd : 32'h0;
            exp_rsp = {ew, !ew, ew && err, !ew && err, ew ? 32'h0 : prd};
            @(negedge clk);
            bus.AWADDR = aw; bus.WDATA = wd; bus.ARADDR = ar;
            bus.AWVALID = mode != 0; bus.WVALID = mode != 0; bus.ARVALID = mode != 1;
            apb_wait = $urandom_range(0, 3); apb_err = err; apb_rdata = prd;
            #1;
            n_run++;
            if ({bus.AWREADY, bus.WREADY, bus.ARREADY} !== (ew ? 3'b110 : 3'b001)) begin
                n_fail++; $display("FAIL rand_grant[%0d]: got %b, expected %b", t, {bus.AWREADY, bus.WREADY, bus.ARREADY}, ew ? 3'b110 : 3'b001);
            end
            @(negedge clk);
            bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.ARVALID = 1'b0;
            cyc = 0; bad = 0;
            while (!(bus.BVALID || bus.RVALID) && cyc < 20) begin
                if (bus.PSEL && (bus.PADDR !== exp_addr || bus.PWRITE !== ew || bus.PWDATA !== exp_wdata)) bad++;
                @(negedge clk);
                cyc++;
            end
            n_run++;
            if (cyc >= 20 || bad != 0) begin
                n_fail++; $display("FAIL rand_apb[%0d]: got %0d cycles with %0d bad, expected <20 and 0", t, cyc, bad);
            end
            obs_rsp = {bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP, bus.RDATA};
            n_run++;
            if (obs_rsp !== exp_rsp) begin
                n_fail++; $display("FAIL rand_resp[%0d]: got %h, expected %h", t, obs_rsp, exp_rsp);
            end
            dly = $urandom_range(0, 2);
            bad = 0;
            repeat (dly) begin
                @(negedge clk);
                if ({bus.BVALID, bus.RVALID, bus.BRESP, bus.RRESP, bus.RDATA} !== exp_rsp) bad++;
            end
            bus.BREADY = 1'b1; bus.RREADY = 1'b1;
            @(negedge clk);
            bus.BREADY = 1'b0; bus.RREADY = 1'b0;
            n_run++;
            if (bad != 0 || {bus.BVALID, bus.RVALID, bus.RDATA} !== 34'h0) begin
                n_fail++; $display("FAIL rand_hold[%0d]: got %0d unstable, valids/data %h, expected 0 and 0", t, bad, {bus.BVALID, bus.RVALID, bus.RDATA});
            end
        end
    endtask

    task automatic test_resp_hold();
        int bad, cyc;
        bit ok;
        logic [31:0] exp;
        @(negedge clk);
        exp = $urandom;
        apb_rdata = exp; apb_wait = $urandom_range(0, 2); apb_err = 1'b0;
        bus.ARADDR = 32'h30; bus.ARVALID = 1'b1; bus.RREADY = 1'b0;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        wait_valid(20, ok);
        bad = 0;
        repeat (4) begin
            if (!bus.RVALID || bus.RDATA !== exp) bad++;
            @(negedge clk);
        end
        n_run++;
        if (!ok || bad != 0 || bus.RVALID !== 1'b1) begin
            n_fail++; $display("FAIL hold_stable: got ok=%b bad=%0d rvalid=%b, expected 1 0 1", ok, bad, bus.RVALID);
        end
        bus.RREADY = 1'b1;
        @(negedge clk);
        bus.RREADY = 1'b0;
        n_run++;
        if ({bus.RVALID, bus.RDATA} !== 33'h0) begin
            n_fail++; $display("FAIL hold_release: got %h, expected 0", {bus.RVALID, bus.RDATA});
        end
        @(negedge clk);
        apb_wait = 10;
        bus.ARADDR = 32'h34; bus.ARVALID = 1'b1;
        @(negedge clk);
        bus.ARVALID = 1'b0;
        cyc = 0;
        while (!bus.PENABLE && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if ({bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR, bus.PWDATA, bus.RVALID, bus.RDATA, bus.ARREADY} !== 101'h0) begin
            n_fail++; $display("FAIL async_reset: got psel=%b penable=%b paddr=%h rvalid=%b, expected all 0", bus.PSEL, bus.PENABLE, bus.PADDR, bus.RVALID);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apb_wait = 0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.RVALID || bus.BVALID || bus.PSEL) bad++;
        end
        n_run++;
        if (bad != 0) begin
            n_fail++; $display("FAIL abandon: got %0d active cycles, expected 0", bad);
        end
    endtask

    // Reset above left the arbiter read-first; all requests held high.
    task automatic test_arbitration();
        int grants, cyc;
        bit busy, ok, g_w, g_r;
        @(negedge clk);
        apb_wait = 0; apb_err = 1'b0;
        bus.AWADDR = 32'h60; bus.WDATA = 32'hA5A5A5A5; bus.ARADDR = 32'h64;
        bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.ARVALID = 1'b1;
        bus.BREADY = 1'b1; bus.RREADY = 1'b1;
        grants = 0; cyc = 0; busy = 1'b0;
        while (grants < 4 && cyc < 60) begin
            #1;
            g_w = bus.AWREADY && bus.WREADY;
            g_r = bus.ARREADY;
            if (g_w || g_r) begin
                n_run++;
                if (busy || (g_w && g_r) || g_r !== (grants % 2 == 0)) begin
                    n_fail++; $display("FAIL arb_order[%0d]: got read=%b write=%b busy=%b, expected read=%b", grants, g_r, g_w, busy, grants % 2 == 0);
                end
                busy = 1'b1;
                grants++;
            end
            if (bus.BVALID || bus.RVALID) busy = 1'b0;
            @(negedge clk);
            cyc++;
        end
        n_run++;
        if (grants != 4) begin
            n_fail++; $display("FAIL arb_count: got %0d grants, expected 4", grants);
        end
        clear_inputs();
        bus.BREADY = 1'b1;
        wait_valid(20, ok);
        @(negedge clk);
        bus.BREADY = 1'b0;
    endtask

    task automatic test_timeout();
        @(negedge clk);
        apb_stall = 1'b1;
        bus.ARADDR = 32'h50; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
        @(negedge clk);
        bus.ARVALID = 1'b0;
`ifdef AXI_APB_BRIDGE_TIMEOUT_EN
        begin
            int cyc, acc;
            cyc = 0; acc = 0;
            while (!bus.RVALID && cyc < 400) begin
                if (bus.PENABLE) acc++;
                @(negedge clk);
                cyc++;
            end
            n_run++;
            if (acc != 256) begin
                n_fail++; $display("FAIL timeout_len: got %0d access cycles, expected 256", acc);
            end
            n_run++;
            if ({bus.RVALID, bus.RRESP, bus.RDATA, bus.PSEL} !== {2'b11, 32'h0, 1'b0}) begin
                n_fail++; $display("FAIL timeout_resp: got %h, expected %h", {bus.RVALID, bus.RRESP, bus.RDATA, bus.PSEL}, {2'b11, 32'h0, 1'b0});
            end
        end
`else
        begin
            int cyc, bad;
            cyc = 0;
            while (!bus.PENABLE && cyc < 5) begin
                @(negedge clk);
                cyc++;
            end
            bad = 0;
            repeat (1000) begin
                if (!bus.PENABLE || !bus.PSEL || bus.RVALID || bus.BVALID) bad++;
                @(negedge clk);
            end
            n_run++;
            if (bad != 0) begin
                n_fail++; $display("FAIL no_timeout: got %0d bad cycles, expected 0", bad);
            end
        end
`endif
        apb_stall = 1'b0;
        do_reset();
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_write_wait();
        test_partial();
        test_random();
        test_resp_hold();
        test_arbitration();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_lite_apb_bridge.md
AXI_LITE_APB_BRIDGE -- requirements
Module: axi_lite_apb_bridge

Interface
REQ-001 Parameter DATA_WIDTH, default 32, data bus width for both AXI-Lite and APB3 sides.
REQ-002 Parameter ADDR_WIDTH, default 32, address width for both sides.
REQ-003 ACLK  input  1  single clock; all logic rising-edge.
REQ-004 ARESETn  input  1  asynchronous active-low reset.
REQ-005 AWADDR/AWVALID/AWPROT  input  ADDR_WIDTH/1/3  write address channel; AWPROT accepted, not forwarded.
REQ-006 AWREADY  output  1  write address accept.
REQ-007 WDATA/WSTRB/WVALID  input  DATA_WIDTH/DATA_WIDTH/8/1  write data channel; WSTRB accepted, not forwarded (APB3 has no strobes).
REQ-008 WREADY  output  1  write data accept.
REQ-009 BRESP/BVALID  output  1/1  write response, BRESP 1 = error; BREADY input 1.
REQ-010 ARADDR/ARVALID  input  ADDR_WIDTH/1; ARREADY output 1  read address channel.
REQ-011 RDATA/RRESP/RVALID  output  DATA_WIDTH/1/1; RREADY input 1  read data channel, RRESP 1 = error.
REQ-012 PADDR/PWDATA  output  ADDR_WIDTH/DATA_WIDTH  APB3 address and write data.
REQ-013 PSEL/PENABLE/PWRITE  output  1 each  APB3 control.
REQ-014 PRDATA  input  DATA_WIDTH; PREADY/PSLVERR  input  1 each  APB3 completer response.

Function
REQ-015 FSM states: IDLE, SETUP, ACCESS, RESP; exactly one transaction in flight.
REQ-016 IDLE: write request = AWVALID && WVALID both high; read request = ARVALID; AW without W (or W without AW) is not a request.
REQ-017 Both requests in same IDLE cycle: arbitration alternates; after a write, read wins next conflict and vice versa; first conflict after reset grants read.
REQ-018 Grant: AWREADY and WREADY (write) or ARREADY (read) high for exactly that one IDLE cycle; address, data and direction latched; next state SETUP.
REQ-019 READY outputs are low in every state other than IDLE-with-grant.
REQ-020 SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA from latches; next state ACCESS unconditionally.
REQ-021 ACCESS: PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA held stable; stay while PREADY=0.
REQ-022 ACCESS with PREADY=1: capture PRDATA (read) and PSLVERR; PSEL, PENABLE low next cycle; next state RESP.
REQ-023 RESP: BVALID (write) or RVALID (read) high with BRESP/RRESP = captured PSLVERR and RDATA = captured PRDATA; held stable until BREADY/RREADY; handshake cycle returns to IDLE.
REQ-024 No new grant in the cycle the response handshake completes; earliest next grant is the following IDLE cycle.
REQ-025 Latency with zero-wait APB and ready master: grant cycle N, PSEL cycle N+1, PENABLE cycle N+2, VALID cycle N+3.
REQ-026 PWDATA drives 0 during reads; RDATA drives 0 when RVALID=0.

Reset
REQ-027 ARESETn low asynchronously forces state IDLE and all outputs 0: AWREADY, WREADY, ARREADY, BVALID, BRESP, RVALID, RRESP, RDATA, PADDR, PWDATA, PSEL, PENABLE, PWRITE.
REQ-028 Reset mid-transaction abandons it with no response generated; arbitration pointer returns to read-first.
REQ-029 Deassertion is taken synchronously; first grant possible on the first ACLK edge after deassertion.

Configuration
REQ-030 Macro AXI_APB_BRIDGE_TIMEOUT_EN defined: 8-bit counter runs in ACCESS; after 256 consecutive cycles with PREADY=0, PSEL/PENABLE drop and RESP is entered with error response (BRESP/RRESP=1, RDATA=0).
REQ-031 Macro undefined: no counter; ACCESS waits on PREADY indefinitely.

Verification
REQ-032 Read, ARADDR=0x10, PREADY=1 immediately, PRDATA=0xDEADBEEF, RREADY=1 -> PSEL at N+1, PENABLE at N+2, RVALID at N+3 with RDATA=0xDEADBEEF, RRESP=0.
REQ-033 Write, AWADDR=0x20, WDATA=0x12345678, PREADY low 3 ACCESS cycles, PSLVERR=1 -> PWRITE=1, PWDATA stable through waits, BVALID with BRESP=1.
REQ-034 AWVALID, WVALID, ARVALID all high continuously for 4 transactions -> order read, write, read, write; never two in flight.
REQ-035 AWVALID high, WVALID low 5 cycles -> no grant, PSEL stays 0; grant on the cycle WVALID rises.
REQ-036 Read complete, RREADY low 4 cycles -> RVALID and RDATA held stable; return to IDLE on RREADY handshake; ARESETn pulse in ACCESS -> all outputs 0 immediately, no RVALID.
REQ-037 With AXI_APB_BRIDGE_TIMEOUT_EN, PREADY held 0 -> RVALID with RRESP=1 after 256 ACCESS cycles; without macro -> PENABLE held for 1000 cycles, no response.
